// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg: funct3 encodings, FSM states and default sizes for the RV32M unit
package ex_muldiv_unit_pkg;
  localparam int MD_WORD_SIZE = 32;
  localparam int MD_NUM_REGS = 32;
  localparam int MD_REG_SEL = $clog2(MD_NUM_REGS);
  typedef enum logic [2:0] {
    MD_OP_MUL, MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU,
    MD_OP_DIV, MD_OP_DIVU, MD_OP_REM, MD_OP_REMU
  } md_op_e;
  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX, MD_DONE} md_state_e;
endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: ID/EX request and EX/MEM response bundle of the muldiv unit
interface ex_muldiv_unit_if #(
  parameter int WORD_SIZE = 32,
  parameter int REG_SEL = 5
);
  logic start, kill, busy, done;
  logic [2:0] md_op;
  logic [WORD_SIZE-1:0] data1, data2, result;
  logic [REG_SEL-1:0] rd, rd_out;
  modport master(output start, md_op, data1, data2, rd, kill, input busy, done, result, rd_out);
  modport slave(input start, md_op, data1, data2, rd, kill, output busy, done, result, rd_out);
endinterface

// File: rtl/ex_muldiv_unit_sign_fix.sv
// ex_muldiv_unit_sign_fix: sign correction of the magnitude result and op-based word select
module ex_muldiv_unit_sign_fix import ex_muldiv_unit_pkg::*; #(
  parameter int WORD_SIZE = MD_WORD_SIZE
) (
  input  logic [2:0]             op,
  input  logic                   sa,
  input  logic                   sb,
  input  logic [2*WORD_SIZE-1:0] acc,
  output logic [WORD_SIZE-1:0]   res
);
  logic [2*WORD_SIZE-1:0] prod;
  logic [WORD_SIZE-1:0] quot, rem;
  always_comb begin
    prod = (sa ^ sb) ? -acc : acc;
    quot = (sa ^ sb) ? -acc[WORD_SIZE-1:0] : acc[WORD_SIZE-1:0];
    rem = sa ? -acc[2*WORD_SIZE-1:WORD_SIZE] : acc[2*WORD_SIZE-1:WORD_SIZE];
    res = op[2] ? (op[1] ? rem : quot)
                : (op == MD_OP_MUL ? prod[WORD_SIZE-1:0] : prod[2*WORD_SIZE-1:WORD_SIZE]);
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide with pipeline stall and one-cycle done
module ex_muldiv_unit import ex_muldiv_unit_pkg::*; #(
  parameter int WORD_SIZE = MD_WORD_SIZE,
  parameter int NUM_REGS = MD_NUM_REGS,
  parameter int REG_SEL = $clog2(NUM_REGS)
) (
  input logic clk,
  input logic rst,
  ex_muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WORD_SIZE);
  localparam logic [WORD_SIZE-1:0] MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};
  md_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WORD_SIZE-1:0] acc_q, acc_d;
  logic [WORD_SIZE-1:0] b_q, b_d, result_q, result_d, fixed;
  logic [2:0] op_q, op_d;
  logic sa_q, sa_d, sb_q, sb_d, sgn1, sgn2, div0, ovf;
  logic [REG_SEL-1:0] rd_q, rd_d, rd_out_q, rd_out_d;
  logic [WORD_SIZE:0] add, sub;
  ex_muldiv_unit_sign_fix #(.WORD_SIZE(WORD_SIZE)) u_fix (
    .op(op_q), .sa(sa_q), .sb(sb_q), .acc(acc_q), .res(fixed)
  );
  // acc holds {hi, lo} for products and {remainder, quotient} for division
  always_comb begin
    sgn1 = bus.data1[WORD_SIZE-1] & !(bus.md_op inside {MD_OP_MULHU, MD_OP_DIVU, MD_OP_REMU});
    sgn2 = bus.data2[WORD_SIZE-1] & (bus.md_op inside {MD_OP_MUL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM});
    div0 = bus.md_op[2] & (bus.data2 == '0);
    ovf = (bus.md_op inside {MD_OP_DIV, MD_OP_REM}) & (bus.data1 == MIN) & (bus.data2 == '1);
    add = {1'b0, acc_q[2*WORD_SIZE-1:WORD_SIZE]} + (acc_q[0] ? {1'b0, b_q} : '0);
    sub = acc_q[2*WORD_SIZE-1:WORD_SIZE-1] - {1'b0, b_q};
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    b_d = b_q;
    op_d = op_q;
    sa_d = sa_q;
    sb_d = sb_q;
    rd_d = rd_q;
    rd_out_d = rd_out_q;
    result_d = result_q;
    if (bus.kill) state_d = MD_IDLE;
    else case (state_q)
      MD_IDLE: if (bus.start) begin
        op_d = bus.md_op;
        rd_d = bus.rd;
        sa_d = sgn1;
        sb_d = sgn2;
        acc_d = {{WORD_SIZE{1'b0}}, sgn1 ? -bus.data1 : bus.data1};
        b_d = sgn2 ? -bus.data2 : bus.data2;
        cnt_d = '0;
        state_d = (div0 | ovf) ? MD_DONE : MD_CALC;
        if (div0 | ovf) begin
          result_d = div0 ? (bus.md_op[1] ? bus.data1 : '1) : (bus.md_op[1] ? '0 : MIN);
          rd_out_d = bus.rd;
        end
      end
      MD_CALC: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = op_q[2] ? {sub[WORD_SIZE] ? acc_q[2*WORD_SIZE-2:WORD_SIZE-1] : sub[WORD_SIZE-1:0],
                           acc_q[WORD_SIZE-2:0], ~sub[WORD_SIZE]}
                        : {add, acc_q[WORD_SIZE-1:1]};
        state_d = (cnt_q == CW'(WORD_SIZE-1)) ? MD_FIX : MD_CALC;
      end
      MD_FIX: begin
        result_d = fixed;
        rd_out_d = rd_q;
        state_d = MD_DONE;
      end
      default: state_d = MD_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      b_q <= '0;
      op_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      rd_q <= '0;
      rd_out_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      b_q <= b_d;
      op_q <= op_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      rd_q <= rd_d;
      rd_out_q <= rd_out_d;
      result_q <= result_d;
    end
  end
  assign bus.busy = (bus.start & (state_q == MD_IDLE)) | (state_q == MD_CALC) | (state_q == MD_FIX);
  assign bus.done = (state_q == MD_DONE) & ~bus.kill;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed scoreboard bench for the iterative RV32M muldiv unit
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;
  typedef struct {logic [31:0] res; logic [4:0] rd; int lat;} exp_t;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  ex_muldiv_unit_if #(.WORD_SIZE(32), .REG_SEL(5)) bus();
  ex_muldiv_unit dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic [31:0] exp, input int lat, input string tag);
    int n = 0;
    int busy_lo = 0;
    exp_t e;
    sb.push_back('{exp, r, lat});
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.data1 = a;
    bus.data2 = b;
    bus.rd = r;
    #1 check({tag, " busy0"}, 32'(bus.busy), 32'd1);
    do begin
      @(posedge clk);
      #1 n++;
      if (!bus.done && !bus.busy) busy_lo++;
    end while (!bus.done && n < 100);
    e = sb.pop_front();
    check({tag, " done"}, 32'(bus.done), 32'd1);
    check({tag, " lat"}, n, e.lat);
    check({tag, " result"}, bus.result, e.res);
    check({tag, " rd_out"}, 32'(bus.rd_out), 32'(e.rd));
    check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, " busy_gaps"}, busy_lo, 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1 check({tag, " pulse"}, 32'(bus.done), 32'd0);
    check({tag, " no_restart"}, 32'(bus.busy), 32'd0);
  endtask
  initial begin
    int seen;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.kill = 1'b0;
    bus.md_op = '0;
    bus.data1 = '0;
    bus.data2 = '0;
    bus.rd = '0;
    repeat (2) @(posedge clk);
    #1 check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst result", bus.result, 32'd0);
    check("rst rd_out", 32'(bus.rd_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(MD_OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 34, "mul");
    run_op(MD_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFE, 34, "mulhu");
    run_op(MD_OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'h00000000, 34, "mulh");
    run_op(MD_OP_MULHSU, 32'hFFFFFFFF, 32'd2, 5'd8, 32'hFFFFFFFF, 34, "mulhsu");
    run_op(MD_OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFD, 34, "div");
    run_op(MD_OP_REM, 32'hFFFFFFF9, 32'd2, 5'd11, 32'hFFFFFFFF, 34, "rem");
    run_op(MD_OP_DIVU, 32'd100, 32'd7, 5'd13, 32'd14, 34, "divu");
    run_op(MD_OP_DIVU, 32'd5, 32'd0, 5'd14, 32'hFFFFFFFF, 1, "divu0");
    run_op(MD_OP_REM, 32'd5, 32'd0, 5'd15, 32'd5, 1, "rem0");
    run_op(MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1, "div_ovf");
    run_op(MD_OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0, 1, "rem_ovf");
    run_op(MD_OP_REMU, 32'd100, 32'd7, 5'd12, 32'd2, 34, "remu");
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = MD_OP_MUL;
    bus.data1 = 32'd5;
    bus.data2 = 32'd6;
    bus.rd = 5'd20;
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.kill = 1'b1;
    bus.start = 1'b0;
    #1 check("kill busy_calc", 32'(bus.busy), 32'd1);
    check("kill done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1 check("kill busy_after", 32'(bus.busy), 32'd0);
    check("kill result_hold", bus.result, 32'd2);
    check("kill rd_hold", 32'(bus.rd_out), 32'd12);
    @(negedge clk);
    bus.kill = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.done) seen++;
    end
    check("kill no_done", seen, 32'd0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.kill = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.kill = 1'b0;
    #1 check("kill_start idle", 32'(bus.busy), 32'd0);
    run_op(MD_OP_MUL, 32'd3, 32'd4, 5'd9, 32'd12, 34, "mul_after_kill");
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = MD_OP_MUL;
    bus.data1 = 32'd9;
    bus.data2 = 32'd9;
    bus.rd = 5'd7;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("arst done", 32'(bus.done), 32'd0);
    check("arst result", bus.result, 32'd0);
    check("arst rd_out", 32'(bus.rd_out), 32'd0);
    bus.start = 1'b0;
    #1 check("arst busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("post_rst busy", 32'(bus.busy), 32'd0);
    check("post_rst done", 32'(bus.done), 32'd0);
    check("scoreboard empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
